// File: rtl/tetris_pkg.sv
// Shared playfield constants and types for the board sequencer and the VGA controller.
// The VGA controller uses GRID_COLS and GRID_ROWS when it maps pixel positions to cells.
package tetris_pkg;

    localparam int GRID_COLS = 10;
    localparam int GRID_ROWS = 15;
    localparam int LINES_W   = 16;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_SCAN,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/tetris_row_collapse.sv
// Combinational collapse of one full row: every row from 1 down to scan_row takes
// the row above it, row 0 becomes empty, and rows below scan_row keep their contents.
module tetris_row_collapse
    import tetris_pkg::*;
#(
    parameter int COLS = GRID_COLS,
    parameter int ROWS = GRID_ROWS
) (
    input  logic [ROWS-1:0][COLS-1:0] grid_i,
    input  logic [3:0]                scan_row_i,
    output logic [ROWS-1:0][COLS-1:0] grid_o
);

    always_comb begin
        grid_o    = grid_i;
        grid_o[0] = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (r <= int'(scan_row_i)) begin
                grid_o[r] = grid_i[r-1];
            end
        end
    end

endmodule

// File: rtl/tetris_board_sequencer.sv
// Owns the placed-cell grid: writes locked pieces, collapses full rows from the bottom up,
// counts the cleared lines, flags game-over, and serves the collision-query and row-read ports.
//
// state    | meaning
// ST_IDLE  | ready for a lock (unless game over)
// ST_LOCK  | write the four latched cells into the grid
// ST_SCAN  | test row scan_row for fullness, moving upward toward row 0
// ST_SHIFT | collapse row scan_row, then rescan the same row
// ST_DONE  | pulse done, publish clear_count, check row 0 for game over
module tetris_board_sequencer
    import tetris_pkg::*;
#(
    parameter int COLS    = GRID_COLS,
    parameter int ROWS    = GRID_ROWS,
    parameter int SCORE_W = LINES_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               lock_valid_i,
    input  logic [3:0]         lock_col0_i,
    input  logic [3:0]         lock_col1_i,
    input  logic [3:0]         lock_col2_i,
    input  logic [3:0]         lock_col3_i,
    input  logic [3:0]         lock_row0_i,
    input  logic [3:0]         lock_row1_i,
    input  logic [3:0]         lock_row2_i,
    input  logic [3:0]         lock_row3_i,
    output logic               lock_ready_o,
    input  logic [3:0]         q_col0_i,
    input  logic [3:0]         q_col1_i,
    input  logic [3:0]         q_col2_i,
    input  logic [3:0]         q_col3_i,
    input  logic [3:0]         q_row0_i,
    input  logic [3:0]         q_row1_i,
    input  logic [3:0]         q_row2_i,
    input  logic [3:0]         q_row3_i,
    output logic               q_hit_o,
    input  logic [3:0]         rd_row_i,
    output logic [COLS-1:0]    rd_data_o,
    output logic               done_o,
    output logic [2:0]         clear_count_o,
    output logic [SCORE_W-1:0] lines_total_o,
    output logic               game_over_o,
    output logic               lock_err_o
);

    cell_t lock_cell [4];
    cell_t q_cell    [4];
    cell_t cells_q   [4];
    cell_t cells_d   [4];

    state_e                   state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] grid_q, grid_d, grid_shift;
    logic [3:0]               scan_row_q, scan_row_d;
    logic [2:0]               clr_cnt_q, clr_cnt_d;
    logic [2:0]               clear_count_q, clear_count_d;
    logic [SCORE_W-1:0]       lines_total_q, lines_total_d;
    logic                     game_over_q, game_over_d;
    logic                     q_hit_q, q_hit_d;

    assign lock_cell[0] = '{col: lock_col0_i, row: lock_row0_i};
    assign lock_cell[1] = '{col: lock_col1_i, row: lock_row1_i};
    assign lock_cell[2] = '{col: lock_col2_i, row: lock_row2_i};
    assign lock_cell[3] = '{col: lock_col3_i, row: lock_row3_i};
    assign q_cell[0]    = '{col: q_col0_i, row: q_row0_i};
    assign q_cell[1]    = '{col: q_col1_i, row: q_row1_i};
    assign q_cell[2]    = '{col: q_col2_i, row: q_row2_i};
    assign q_cell[3]    = '{col: q_col3_i, row: q_row3_i};

    function automatic logic in_grid(cell_t c);
        return (int'(c.col) < COLS) && (int'(c.row) < ROWS);
    endfunction

    tetris_row_collapse #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_row_collapse (
        .grid_i     (grid_q),
        .scan_row_i (scan_row_q),
        .grid_o     (grid_shift)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            cells_q       <= '{default: '0};
            grid_q        <= '0;
            scan_row_q    <= '0;
            clr_cnt_q     <= '0;
            clear_count_q <= '0;
            lines_total_q <= '0;
            game_over_q   <= 1'b0;
            q_hit_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cells_q       <= cells_d;
            grid_q        <= grid_d;
            scan_row_q    <= scan_row_d;
            clr_cnt_q     <= clr_cnt_d;
            clear_count_q <= clear_count_d;
            lines_total_q <= lines_total_d;
            game_over_q   <= game_over_d;
            q_hit_q       <= q_hit_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cells_d       = cells_q;
        grid_d        = grid_q;
        scan_row_d    = scan_row_q;
        clr_cnt_d     = clr_cnt_q;
        clear_count_d = clear_count_q;
        lines_total_d = lines_total_q;
        game_over_d   = game_over_q;
        lock_ready_o  = 1'b0;
        done_o        = 1'b0;
        lock_err_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lock_ready_o = !game_over_q;
                if (lock_valid_i && !game_over_q) begin
                    cells_d   = lock_cell;
                    clr_cnt_d = '0;
                    state_d   = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // Off-grid cells are dropped; the rest of the piece still lands.
                for (int i = 0; i < 4; i++) begin
                    if (in_grid(cells_q[i])) begin
                        grid_d[cells_q[i].row][cells_q[i].col] = 1'b1;
                    end else begin
                        lock_err_o = 1'b1;
                    end
                end
                scan_row_d = 4'(ROWS - 1);
                state_d    = ST_SCAN;
            end
            ST_SCAN: begin
                if (&grid_q[scan_row_q]) begin
                    state_d = ST_SHIFT;
                end else if (scan_row_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    scan_row_d = scan_row_q - 4'd1;
                end
            end
            ST_SHIFT: begin
                grid_d    = grid_shift;
                clr_cnt_d = clr_cnt_q + 3'd1;
                if (lines_total_q != '1) begin
                    lines_total_d = lines_total_q + SCORE_W'(1);
                end
                state_d = ST_SCAN;
            end
            ST_DONE: begin
                done_o        = 1'b1;
                clear_count_d = clr_cnt_q;
                if (|grid_q[0]) begin
                    game_over_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Walls and floor count as occupied so the falling-piece logic needs no bounds check.
    always_comb begin
        q_hit_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!in_grid(q_cell[i])) begin
                q_hit_d = 1'b1;
            end else if (grid_q[q_cell[i].row][q_cell[i].col]) begin
                q_hit_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (int'(rd_row_i) < ROWS) begin
            rd_data_o = grid_q[rd_row_i];
        end
    end

    assign clear_count_o = (state_q == ST_DONE) ? clr_cnt_q : clear_count_q;
    assign q_hit_o       = q_hit_q;
    assign lines_total_o = lines_total_q;
    assign game_over_o   = game_over_q;

endmodule
